fetch_queue: RTL and testbench

//  Fetch stage of the dual-issue pipeline, directly upstream of decode.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage for the dual-issue pipeline: owns the PC, captures two instruction
// words per cycle into a circular queue and presents the two oldest to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              im_addr,
  input  logic [31:0]              im_data,
  input  logic [31:0]              im_data1,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic [1:0]               dec_take,
  output logic                     out_valid0,
  output logic [31:0]              out_inst0,
  output logic [31:0]              out_pc0,
  output logic                     out_valid1,
  output logic [31:0]              out_inst1,
  output logic [31:0]              out_pc1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Decode handshake: out_valid0/out_valid1 mark the two oldest entries as
  // offered; dec_take is decode's acceptance count for this cycle. Only offered
  // entries can be consumed, so a request beyond the valid count is clipped
  // and values of 3 are treated as 2.

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_r;
  logic [31:0]   pc;

  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [CW-1:0] free;
  logic [1:0]    take_req;
  logic [1:0]    take_eff;
  logic [1:0]    push_cnt;

  logic [PW-1:0] head_next;
  logic [PW-1:0] tail_next;
  logic [CW-1:0] count_next;
  logic [31:0]   pc_next;

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  // Push depends only on occupancy before this cycle's pop, which keeps
  // dec_take off the path into the instruction memory and the PC.
  assign free = CW'(DEPTH) - count_r;

  always_comb begin
    push_cnt = 2'd0;
    if (free >= CW'(2)) begin
      push_cnt = 2'd2;
    end else if (free == CW'(1)) begin
      push_cnt = 2'd1;
    end
  end

  always_comb begin
    take_req = (dec_take == 2'd3) ? 2'd2 : dec_take;
    take_eff = take_req;
    if (CW'(take_req) > count_r) begin
      take_eff = count_r[1:0];
    end
  end

  always_comb begin
    head_next  = head + PW'(take_eff);
    tail_next  = tail + PW'(push_cnt);
    count_next = count_r - CW'(take_eff) + CW'(push_cnt);
    pc_next    = pc + {28'd0, push_cnt, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      pc      <= RESET_PC;
    end else if (redirect) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      pc      <= {redirect_pc[31:2], 2'b00};
    end else begin
      head    <= head_next;
      tail    <= tail_next;
      count_r <= count_next;
      pc      <= pc_next;
    end
  end

  // Entry storage. Redirect leaves stale contents in place; they are hidden
  // because count is zero and the valids derive from count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (!redirect) begin
      if (push_cnt != 2'd0) begin
        inst_q[tail] <= im_data;
        pc_q[tail]   <= pc;
      end
      if (push_cnt == 2'd2) begin
        inst_q[tail_p1] <= im_data1;
        pc_q[tail_p1]   <= pc + 32'd4;
      end
    end
  end

  assign im_addr    = pc;
  assign count      = count_r;
  assign out_valid0 = (count_r >= CW'(1));
  assign out_valid1 = (count_r >= CW'(2));
  assign out_inst0  = inst_q[head];
  assign out_pc0    = pc_q[head];
  assign out_inst1  = inst_q[head_p1];
  assign out_pc1    = pc_q[head_p1];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue with a simple instruction memory
// whose word at address a is 32'h1000_0000 + a/4.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] im_data1;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dec_take;
  logic        out_valid0;
  logic [31:0] out_inst0;
  logic [31:0] out_pc0;
  logic        out_valid1;
  logic [31:0] out_inst1;
  logic [31:0] out_pc1;
  logic [2:0]  count;

  int n_vec;
  int n_err;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .im_addr(im_addr), .im_data(im_data),
    .im_data1(im_data1), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_take(dec_take), .out_valid0(out_valid0), .out_inst0(out_inst0),
    .out_pc0(out_pc0), .out_valid1(out_valid1), .out_inst1(out_inst1),
    .out_pc1(out_pc1), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign im_data  = mw(im_addr);
  assign im_data1 = mw(im_addr + 32'd4);

  typedef struct {
    string       name;
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic [1:0]  take;
    logic [2:0]  e_count;
    logic        e_v0;
    logic        e_v1;
    logic        chk_data;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
    logic [31:0] e_inst0;
    logic [31:0] e_inst1;
    logic [31:0] e_im;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic rst, input logic redir,
                              input logic [31:0] rpc, input logic [1:0] take,
                              input logic [2:0] e_count, input logic chk_data,
                              input logic [31:0] e_pc0, input logic [31:0] e_pc1,
                              input logic [31:0] e_inst0, input logic [31:0] e_inst1,
                              input logic [31:0] e_im);
    vec_t v;
    v.name = name; v.rst = rst; v.redir = redir; v.rpc = rpc; v.take = take;
    v.e_count = e_count; v.e_v0 = (e_count >= 3'd1); v.e_v1 = (e_count >= 3'd2);
    v.chk_data = chk_data; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
    v.e_inst0 = e_inst0; v.e_inst1 = e_inst1; v.e_im = e_im;
    return v;
  endfunction

  // scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns after rising edge
  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic [1:0] take);
    @(negedge clk);
    reset = rst; redirect = redir; redirect_pc = rpc; dec_take = take;
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic check_state(input string name, input logic [2:0] e_count,
                             input logic chk_data, input logic [31:0] e_pc0,
                             input logic [31:0] e_pc1, input logic [31:0] e_inst0,
                             input logic [31:0] e_inst1, input logic [31:0] e_im);
    chk({name, ".count"},  {29'd0, count},       {29'd0, e_count});
    chk({name, ".valid0"}, {31'd0, out_valid0},  {31'd0, e_count >= 3'd1});
    chk({name, ".valid1"}, {31'd0, out_valid1},  {31'd0, e_count >= 3'd2});
    chk({name, ".im_addr"}, im_addr, e_im);
    if (chk_data) begin
      chk({name, ".pc0"},   out_pc0,   e_pc0);
      chk({name, ".pc1"},   out_pc1,   e_pc1);
      chk({name, ".inst0"}, out_inst0, e_inst0);
      chk({name, ".inst1"}, out_inst1, e_inst1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; dec_take = 2'd0;

    //          name        rst   rdr   rpc           tk  cnt chk pc0           pc1           inst0           inst1           im_addr
    vecs.push_back(mk("rst_a",   1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 1'b1, 32'h0,  32'h0,  32'h0,    32'h0,    32'h0));
    vecs.push_back(mk("rst_b",   1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 1'b1, 32'h0,  32'h0,  32'h0,    32'h0,    32'h0));
    vecs.push_back(mk("fill1",   1'b0, 1'b0, 32'h0,        2'd0, 3'd2, 1'b1, 32'h0,  32'h4,  mw(0),    mw(4),    32'h8));
    vecs.push_back(mk("fill2",   1'b0, 1'b0, 32'h0,        2'd0, 3'd4, 1'b1, 32'h0,  32'h4,  mw(0),    mw(4),    32'h10));
    vecs.push_back(mk("full",    1'b0, 1'b0, 32'h0,        2'd0, 3'd4, 1'b1, 32'h0,  32'h4,  mw(0),    mw(4),    32'h10));
    vecs.push_back(mk("take1",   1'b0, 1'b0, 32'h0,        2'd1, 3'd3, 1'b1, 32'h4,  32'h8,  mw(4),    mw(8),    32'h10));
    vecs.push_back(mk("push1",   1'b0, 1'b0, 32'h0,        2'd0, 3'd4, 1'b1, 32'h4,  32'h8,  mw(4),    mw(8),    32'h14));
    vecs.push_back(mk("take3f",  1'b0, 1'b0, 32'h0,        2'd3, 3'd2, 1'b1, 32'hC,  32'h10, mw(32'hC), mw(32'h10), 32'h14));
    vecs.push_back(mk("take3c2", 1'b0, 1'b0, 32'h0,        2'd3, 3'd2, 1'b1, 32'h14, 32'h18, mw(32'h14), mw(32'h18), 32'h1C));
    vecs.push_back(mk("dual_a",  1'b0, 1'b0, 32'h0,        2'd2, 3'd2, 1'b1, 32'h1C, 32'h20, mw(32'h1C), mw(32'h20), 32'h24));
    vecs.push_back(mk("dual_b",  1'b0, 1'b0, 32'h0,        2'd2, 3'd2, 1'b1, 32'h24, 32'h28, mw(32'h24), mw(32'h28), 32'h2C));
    vecs.push_back(mk("refill",  1'b0, 1'b0, 32'h0,        2'd0, 3'd4, 1'b1, 32'h24, 32'h28, mw(32'h24), mw(32'h28), 32'h34));
    vecs.push_back(mk("to_c3",   1'b0, 1'b0, 32'h0,        2'd1, 3'd3, 1'b1, 32'h28, 32'h2C, mw(32'h28), mw(32'h2C), 32'h34));
    vecs.push_back(mk("redir",   1'b0, 1'b1, 32'h43,       2'd2, 3'd0, 1'b0, 32'h0,  32'h0,  32'h0,    32'h0,    32'h40));
    vecs.push_back(mk("newpath", 1'b0, 1'b0, 32'h0,        2'd2, 3'd2, 1'b1, 32'h40, 32'h44, mw(32'h40), mw(32'h44), 32'h48));
    vecs.push_back(mk("fill3",   1'b0, 1'b0, 32'h0,        2'd0, 3'd4, 1'b1, 32'h40, 32'h44, mw(32'h40), mw(32'h44), 32'h50));
    vecs.push_back(mk("rst_rdr", 1'b1, 1'b1, 32'h100,      2'd2, 3'd0, 1'b1, 32'h0,  32'h0,  32'h0,    32'h0,    32'h0));
    vecs.push_back(mk("rst_out", 1'b0, 1'b0, 32'h0,        2'd0, 3'd2, 1'b1, 32'h0,  32'h4,  mw(0),    mw(4),    32'h8));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].take);
      check_state(vecs[i].name, vecs[i].e_count, vecs[i].chk_data, vecs[i].e_pc0,
                  vecs[i].e_pc1, vecs[i].e_inst0, vecs[i].e_inst1, vecs[i].e_im);
    end

    // PC wrap through 32'hFFFFFFFC and queue pointer wrap with mixed takes
    drive(1'b0, 1'b1, 32'hFFFF_FFF9, 2'd0);
    check_state("wrap_redir", 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8);
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    check_state("wrap_fill", 3'd2, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 2'd1);
    check_state("wrap_cross", 3'd3, 1'b1, 32'hFFFF_FFFC, 32'h0,
                32'h4FFF_FFFF, 32'h1000_0000, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 2'd2);
    check_state("wrap_ptr", 3'd2, 1'b1, 32'h4, 32'h8,
                32'h1000_0001, 32'h1000_0002, 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
